// File: rtl/data_unpack.sv
// Splits a packetised MSB-first stream of IN_WIDTH-bit words into OUT_WIDTH-bit symbols; first symbol one cycle after acceptance.
// Input is stalled (ready_out low) while a full symbol is buffered or an end-of-packet flush is pending; output is never stalled.
module data_unpack #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready_out,
  input  logic                 valid_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 sop_in,
  input  logic                 eop_in,
  output logic                 valid_out,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 sop_out,
  output logic                 eop_out
);

  localparam int BUF_W = IN_WIDTH + OUT_WIDTH - 1;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_WIDTH);
  localparam logic [CNT_W-1:0] IN_W_C  = CNT_W'(IN_WIDTH);

  logic [BUF_W-1:0] bit_buf;
  logic [CNT_W-1:0] cnt;
  logic             sop_pend;
  logic             eop_pend;
  logic [BUF_W-1:0] word_aligned;
  logic             accept;

  // Bits below cnt are always zero, so a new word can simply be OR-ed in under the residue.
  assign word_aligned = (BUF_W'(data_in) << (OUT_WIDTH - 1)) >> cnt;
  assign ready_out    = (cnt < OUT_W_C) && !eop_pend;
  assign accept       = valid_in && ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_buf   <= '0;
      cnt       <= '0;
      sop_pend  <= 1'b0;
      eop_pend  <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      if (cnt >= OUT_W_C) begin
        valid_out <= 1'b1;
        data_out  <= bit_buf[BUF_W-1 -: OUT_WIDTH];
        sop_out   <= sop_pend;
        sop_pend  <= 1'b0;
        bit_buf   <= bit_buf << OUT_WIDTH;
        cnt       <= cnt - OUT_W_C;
        if (eop_pend && (cnt == OUT_W_C)) begin
          eop_out  <= 1'b1;
          eop_pend <= 1'b0;
        end
      end else if (eop_pend) begin
        // Residue is already left-aligned with zeros beneath it, so the top slice is the padded symbol.
        if (cnt != '0) begin
          valid_out <= 1'b1;
          data_out  <= bit_buf[BUF_W-1 -: OUT_WIDTH];
          sop_out   <= sop_pend;
          eop_out   <= 1'b1;
          sop_pend  <= 1'b0;
        end
        bit_buf  <= '0;
        cnt      <= '0;
        eop_pend <= 1'b0;
      end else if (accept) begin
        bit_buf <= bit_buf | word_aligned;
        cnt     <= cnt + IN_W_C;
        if (sop_in) sop_pend <= 1'b1;
        if (eop_in) eop_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_unpack.sv
// Randomised and directed bench for data_unpack against a bit-queue reference model.
module tb_data_unpack;

  localparam int IW = 32;
  localparam int OW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready_out;
  logic          valid_in = 1'b0;
  logic [IW-1:0] data_in = '0;
  logic          sop_in = 1'b0;
  logic          eop_in = 1'b0;
  logic          valid_out;
  logic [OW-1:0] data_out;
  logic          sop_out;
  logic          eop_out;

  data_unpack #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .ready_out(ready_out), .valid_in(valid_in),
    .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
    .valid_out(valid_out), .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic sop; logic eop; logic [OW-1:0] dat;} sym_t;
  typedef struct packed {logic sop; logic eop; logic [IW-1:0] dat;} beat_t;

  beat_t beats[$];
  sym_t  exp_q[$];
  sym_t  got[$];
  bit    bitq[$];
  bit    sop_flag;
  bit    eop_wait;
  int    just_added;
  int    vld_pct = 100;
  int    checks = 0;
  int    errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  // Reference: append word bits to a flat bit list and cut 7-bit symbols off the front.
  task automatic model_accept(input beat_t b, output int added);
    sym_t s;
    added = 0;
    for (int i = IW - 1; i >= 0; i--) bitq.push_back(b.dat[i]);
    if (b.sop) sop_flag = 1'b1;
    while (bitq.size() >= OW) begin
      s.dat = '0;
      for (int i = OW - 1; i >= 0; i--) s.dat[i] = bitq.pop_front();
      s.sop = sop_flag;
      sop_flag = 1'b0;
      s.eop = b.eop && (bitq.size() == 0);
      exp_q.push_back(s);
      added++;
    end
    if (b.eop && bitq.size() > 0) begin
      s.dat = '0;
      for (int i = OW - 1; bitq.size() > 0; i--) s.dat[i] = bitq.pop_front();
      s.sop = sop_flag;
      sop_flag = 1'b0;
      s.eop = 1'b1;
      exp_q.push_back(s);
      added++;
    end
    if (b.eop) eop_wait = 1'b1;
  endtask

  task automatic step();
    sym_t s;
    sym_t e;
    int   added;
    @(negedge clk);
    if (valid_out) begin
      s = {sop_out, eop_out, data_out};
      got.push_back(s);
      if (exp_q.size() == 0) begin
        check_eq("spurious_symbol", valid_out, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_eq("symbol", s, e);
      end
      if (eop_out) begin
        check_eq("ready_after_eop", ready_out, 1'b1);
        eop_wait = 1'b0;
      end else if (eop_wait) begin
        check_eq("ready_during_eop", ready_out, 1'b0);
      end
    end else begin
      check_eq("idle_outputs", {sop_out, eop_out, data_out}, '0);
      if (exp_q.size() > just_added) check_eq("gap", valid_out, 1'b1);
      if (eop_wait) check_eq("ready_during_eop", ready_out, 1'b0);
    end
    just_added = 0;
    if (beats.size() > 0 && $urandom_range(99) < vld_pct) begin
      valid_in = 1'b1;
      {sop_in, eop_in, data_in} = beats[0];
      if (ready_out) begin
        model_accept(beats.pop_front(), added);
        just_added = added;
      end
    end else begin
      valid_in = 1'b0;
      data_in  = $urandom;
      sop_in   = 1'($urandom_range(1));
      eop_in   = 1'($urandom_range(1));
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (beats.size() > 0 || exp_q.size() > 0 || eop_wait) begin
      step();
      n++;
      if (n > budget) begin
        check_eq("timeout", n, budget);
        break;
      end
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", valid_out, 1'b0);
    check_eq("rst_data", data_out, '0);
    check_eq("rst_sop_eop", {sop_out, eop_out}, 2'b00);
    check_eq("rst_ready", ready_out, 1'b1);
    rst = 1'b0;
    beats.delete();
    exp_q.delete();
    bitq.delete();
    sop_flag = 1'b0;
    eop_wait = 1'b0;
    just_added = 0;
  endtask

  task automatic push(input logic [IW-1:0] d, input logic s, input logic e);
    beat_t b;
    b.dat = d;
    b.sop = s;
    b.eop = e;
    beats.push_back(b);
  endtask

  int n_sop;
  int n_eop;
  int n_pkts;
  int nw;

  initial begin
    do_reset();

    // Single-word packet
    got.delete();
    push(32'h12345678, 1'b1, 1'b1);
    run(100);
    check_eq("single_count", got.size(), 5);
    if (got.size() == 5) begin
      check_eq("single_s0", got[0], {1'b1, 1'b0, 7'h09});
      check_eq("single_s1", got[1], {1'b0, 1'b0, 7'h0D});
      check_eq("single_s2", got[2], {1'b0, 1'b0, 7'h0A});
      check_eq("single_s3", got[3], {1'b0, 1'b0, 7'h67});
      check_eq("single_s4", got[4], {1'b0, 1'b1, 7'h40});
    end

    // Word-boundary span
    got.delete();
    push(32'h12345678, 1'b1, 1'b0);
    push(32'h9ABCDEF0, 1'b0, 1'b1);
    run(100);
    check_eq("span_count", got.size(), 10);
    if (got.size() == 10) begin
      check_eq("span_s0", got[0], {1'b1, 1'b0, 7'h09});
      check_eq("span_s3", got[3], {1'b0, 1'b0, 7'h67});
      check_eq("span_s4", got[4], {1'b0, 1'b0, 7'h44});
      check_eq("span_last_eop", got[9].eop, 1'b1);
    end

    // Exact fill: 8 words -> 36 full symbols plus a 4-bit padded one
    got.delete();
    for (int i = 0; i < 7; i++) push($urandom, i == 0, 1'b0);
    push(32'hAAAAAAAA, 1'b0, 1'b1);
    run(200);
    check_eq("fill_count", got.size(), 37);
    if (got.size() == 37) begin
      check_eq("fill_s32", got[32], {1'b0, 1'b0, 7'h55});
      check_eq("fill_s33", got[33], {1'b0, 1'b0, 7'h2A});
      check_eq("fill_s34", got[34], {1'b0, 1'b0, 7'h55});
      check_eq("fill_s35", got[35], {1'b0, 1'b0, 7'h2A});
      check_eq("fill_s36", got[36], {1'b0, 1'b1, 7'h50});
    end
    n_sop = 0;
    n_eop = 0;
    foreach (got[i]) begin
      n_sop += int'(got[i].sop);
      n_eop += int'(got[i].eop);
    end
    check_eq("fill_sop_count", n_sop, 1);
    check_eq("fill_eop_count", n_eop, 1);

    // Back-to-back packets
    got.delete();
    push(32'h12345678, 1'b1, 1'b1);
    push(32'hFFFFFFFF, 1'b1, 1'b1);
    run(100);
    check_eq("b2b_count", got.size(), 10);
    if (got.size() == 10) begin
      check_eq("b2b_s5", got[5], {1'b1, 1'b0, 7'h7F});
      check_eq("b2b_s9", got[9], {1'b0, 1'b1, 7'h78});
    end

    // Mid-packet reset with residual bits, then a clean packet
    push(32'h12345678, 1'b1, 1'b0);
    run(100);
    do_reset();
    got.delete();
    push(32'hFFFFFFFF, 1'b1, 1'b1);
    run(100);
    check_eq("post_rst_count", got.size(), 5);
    if (got.size() == 5) begin
      check_eq("post_rst_s0", got[0], {1'b1, 1'b0, 7'h7F});
      check_eq("post_rst_s4", got[4], {1'b0, 1'b1, 7'h78});
    end

    // Randomised handshake stress
    got.delete();
    vld_pct = 55;
    n_pkts = 30;
    for (int p = 0; p < n_pkts; p++) begin
      nw = $urandom_range(1, 8);
      for (int w = 0; w < nw; w++) push($urandom, w == 0, w == nw - 1);
    end
    run(5000);
    n_sop = 0;
    n_eop = 0;
    foreach (got[i]) begin
      n_sop += int'(got[i].sop);
      n_eop += int'(got[i].eop);
    end
    check_eq("rand_sop_count", n_sop, n_pkts);
    check_eq("rand_eop_count", n_eop, n_pkts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
